bf_candidate_gen: RTL and testbench

- Parametrised brute-force password candidate generator; successor to the fixed 128-bit, free-running generator.
- Enumerates strings over a contiguous character range as an odometer, growing word length on overflow, up to a run-time length limit.
- Adds start/stop control, a valid/ready output handshake, strided enumeration for N parallel lanes (lane k: start offset k, stride N), a done indication and a candidate counter.
- Feeds a downstream hash/compare stage.

---
 rtl/bf_pkg.sv | 23 ++
 rtl/bf_digit_add.sv | 43 ++++
 rtl/bf_candidate_gen.sv | 144 ++++++++++++++
 tb/tb_bf_candidate_gen.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared types and helpers for the brute-force candidate generator.
// State encoding, default alphabet bounds and length-limit clamping.
package bf_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] CHAR_LO_DEF = 8'h61;
   localparam logic [7:0] CHAR_HI_DEF = 8'h7A;

   // 0 means a single character; anything above the bus width is capped.
   function automatic int clamp_len(input int lim, input int max_len);
      if (lim == 0)
         return 1;
      if (lim > max_len)
         return max_len;
      return lim;
   endfunction

endpackage

// File: rtl/bf_digit_add.sv
// One odometer digit: adds 0..7 to a character in the alphabet range.
// Wraps at the alphabet size and reports a single carry.
module bf_digit_add
   import bf_pkg::*;
#(
   parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
   parameter logic [7:0] CHAR_HI = CHAR_HI_DEF
) (
   input  logic [7:0] ch,
   input  logic [2:0] add,
   input  logic       en,
   output logic [7:0] ch_out,
   output logic       carry
);

   localparam logic [8:0] NCH =
      {1'b0, CHAR_HI} - {1'b0, CHAR_LO} + 9'd1;

   logic [8:0] idx;
   logic [8:0] sum;
   logic [8:0] wrapped;
   logic [8:0] chr;

   // Index arithmetic; disabled digits pass through untouched.
   always_comb begin
      idx     = {1'b0, ch} - {1'b0, CHAR_LO};
      sum     = idx + {6'd0, add};
      wrapped = sum;
      carry   = 1'b0;
      if (sum >= NCH) begin
         wrapped = sum - NCH;
         carry   = 1'b1;
      end
      chr    = wrapped + {1'b0, CHAR_LO};
      ch_out = ch;
      if (en) begin
         ch_out = chr[7:0];
      end else begin
         carry = 1'b0;
      end
   end

endmodule

// File: rtl/bf_candidate_gen.sv
// Strided odometer candidate generator with valid/ready output.
// Grows word length on overflow up to a per-run length limit.
module bf_candidate_gen
   import bf_pkg::*;
#(
   parameter int         MAX_LEN = 16,
   parameter logic [7:0] CHAR_LO = CHAR_LO_DEF,
   parameter logic [7:0] CHAR_HI = CHAR_HI_DEF,
   parameter int         LEN_W   = 5,
   parameter int         CNT_W   = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   stop,
   input  logic [7:0]             start_char,
   input  logic [2:0]             stride,
   input  logic [LEN_W-1:0]       len_limit,
   input  logic                   out_ready,
   output logic                   out_valid,
   output logic [8*MAX_LEN-1:0]   password,
   output logic [LEN_W-1:0]       word_len,
   output logic                   busy,
   output logic                   done,
   output logic [CNT_W-1:0]       cand_count
);

   state_t                  state_q, state_d;
   logic [MAX_LEN-1:0][7:0] pw_q, pw_nx, sum;
   logic [MAX_LEN-1:0][2:0] add;
   logic [MAX_LEN-1:0]      cy, en;
   logic [LEN_W-1:0]        wlen_q, lim_q, lim_cl;
   logic [2:0]              stride_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [7:0]              sc_cl;
   logic                    top_c, last, grow, adv, go;

   genvar g;
   generate
      for (g = 0; g < MAX_LEN; g++) begin : g_dig
         assign en[g] = (LEN_W'(g) < wlen_q);
         if (g == 0) begin : g_lsd
            assign add[g] = stride_q;
         end else begin : g_hi
            assign add[g] = {2'b00, cy[g-1]};
         end
         bf_digit_add #(
            .CHAR_LO(CHAR_LO),
            .CHAR_HI(CHAR_HI)
         ) u_dig (
            .ch    (pw_q[g]),
            .add   (add[g]),
            .en    (en[g]),
            .ch_out(sum[g]),
            .carry (cy[g])
         );
      end
   endgenerate

   assign adv    = (state_q == S_RUN) && out_ready;
   assign go     = start && !stop;
   assign sc_cl  = (start_char < CHAR_LO || start_char > CHAR_HI)
                 ? CHAR_LO : start_char;
   assign lim_cl = LEN_W'(clamp_len(int'(len_limit), MAX_LEN));
   assign last   = top_c && (wlen_q >= lim_q);
   assign grow   = top_c && !last;

   // Carry out of the current most-significant digit.
   always_comb begin
      top_c = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (LEN_W'(k + 1) == wlen_q)
            top_c = cy[k];
      end
   end

   // Next string: wrapped digits plus a fresh top digit on growth.
   always_comb begin
      pw_nx = sum;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (grow && LEN_W'(k) == wlen_q)
            pw_nx[k] = CHAR_LO;
      end
   end

   // Next-state logic; stop has priority over everything.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (go) state_d = S_RUN;
         S_RUN: begin
            if (stop)
               state_d = S_IDLE;
            else if (adv && last)
               state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Run setup in IDLE, odometer advance on each handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pw_q     <= '0;
         wlen_q   <= '0;
         lim_q    <= LEN_W'(1);
         stride_q <= 3'd1;
         cnt_q    <= '0;
      end else if (state_q == S_IDLE) begin
         if (go) begin
            pw_q     <= {{(8*(MAX_LEN-1)){1'b0}}, sc_cl};
            wlen_q   <= LEN_W'(1);
            lim_q    <= lim_cl;
            stride_q <= (stride == 3'd0) ? 3'd1 : stride;
            cnt_q    <= '0;
         end
      end else if (adv) begin
         if (~&cnt_q)
            cnt_q <= cnt_q + CNT_W'(1);
         if (!last) begin
            pw_q <= pw_nx;
            if (grow)
               wlen_q <= wlen_q + LEN_W'(1);
         end
      end
   end

   assign out_valid  = (state_q == S_RUN);
   assign busy       = (state_q == S_RUN);
   assign done       = (state_q == S_DONE);
   assign password   = pw_q;
   assign word_len   = wlen_q;
   assign cand_count = cnt_q;

endmodule

// File: tb/tb_bf_candidate_gen.sv
// Scoreboard bench for bf_candidate_gen.
// Expected candidates come from a numeric base-26 model of the run.
module tb_bf_candidate_gen;

   localparam int MAX_LEN = 16;
   localparam int LEN_W   = 5;
   localparam int CNT_W   = 32;
   localparam int NCH     = 26;
   localparam int LO      = 'h61;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic                 stop = 1'b0;
   logic [7:0]           start_char = 8'h00;
   logic [2:0]           stride = 3'd0;
   logic [LEN_W-1:0]     len_limit = '0;
   logic                 out_ready = 1'b0;
   logic                 out_valid;
   logic [8*MAX_LEN-1:0] password;
   logic [LEN_W-1:0]     word_len;
   logic                 busy;
   logic                 done;
   logic [CNT_W-1:0]     cand_count;

   bf_candidate_gen dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stop      (stop),
      .start_char(start_char),
      .stride    (stride),
      .len_limit (len_limit),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .password  (password),
      .word_len  (word_len),
      .busy      (busy),
      .done      (done),
      .cand_count(cand_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] pw;
      int           wl;
      int           cnt;
   } exp_t;

   exp_t         sbq[$];
   exp_t         e;
   int           checks = 0;
   int           errors = 0;
   int           acc_cnt = 0;
   int           done_cnt = 0;
   int           exp_total = 0;
   exp_t         exp_last;
   logic         hold_v = 1'b0;
   logic [127:0] hold_pw;
   logic [31:0]  hold_cnt;

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mkpw(input longint unsigned v,
                                         input int len);
      logic [127:0] p = '0;
      for (int i = 0; i < len; i++) begin
         p[8*i +: 8] = 8'(LO + int'(v % NCH));
         v = v / NCH;
      end
      return p;
   endfunction

   function automatic longint unsigned space(input int len);
      longint unsigned p = 1;
      for (int i = 0; i < len; i++) p = p * NCH;
      return p;
   endfunction

   // The run is a number counting up by the stride; overflow of the
   // current length either grows the word or ends the run.
   task automatic build(input logic [7:0] sc, input int st, input int lim);
      longint unsigned v, p;
      int len = 1;
      int n = 0;
      v = (sc < 8'h61 || sc > 8'h7a) ? 0 : longint'(sc) - LO;
      if (st == 0) st = 1;
      if (lim == 0) lim = 1;
      if (lim > MAX_LEN) lim = MAX_LEN;
      sbq.delete();
      forever begin
         sbq.push_back('{mkpw(v, len), len, n});
         n++;
         v = v + longint'(st);
         p = space(len);
         if (v >= p) begin
            if (len < lim) begin
               v = v - p;
               len++;
            end else break;
         end
      end
      exp_total = n;
      exp_last  = sbq[$];
   endtask

   // Monitor: pops on every handshake, checks stability under stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (done) begin
            done_cnt++;
            chk("done_queue_empty", sbq.size(), 0);
         end
         if (out_valid) begin
            if (hold_v) begin
               chk("hold_pw", password, hold_pw);
               chk("hold_cnt", cand_count, hold_cnt);
            end
            if (out_ready) begin
               checks++;
               if (sbq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_cand: got %0h expected none",
                           password);
               end else begin
                  e = sbq.pop_front();
                  chk("cand_pw", password, e.pw);
                  chk("cand_len", word_len, e.wl);
                  chk("cand_cnt", cand_count, e.cnt);
               end
               acc_cnt++;
               hold_v = 1'b0;
            end else begin
               hold_v   = 1'b1;
               hold_pw  = password;
               hold_cnt = cand_count;
            end
         end else begin
            hold_v = 1'b0;
         end
      end
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_len"}, word_len, 0);
      chk({tag, "_pw"}, password, 0);
      chk({tag, "_cnt"}, cand_count, 0);
   endtask

   task automatic run(input logic [7:0] sc, input logic [2:0] st,
                      input logic [4:0] lim, input int rdy_pct,
                      input int stop_at, input int hold_at,
                      input int rst_at);
      int  d0;
      int  cyc = 0;
      bit  fin = 0;
      build(sc, int'(st), int'(lim));
      d0 = done_cnt;
      @(posedge clk); #1;
      acc_cnt    = 0;
      start      = 1'b1;
      start_char = sc;
      stride     = st;
      len_limit  = lim;
      stop       = 1'b0;
      out_ready  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_valid", out_valid, 1);
      chk("start_busy", busy, 1);
      chk("first_pw", password, sbq[0].pw);
      chk("first_len", word_len, 1);
      chk("first_cnt", cand_count, 0);
      while (!fin) begin
         if (rst_at >= 0 && acc_cnt == rst_at) begin
            chk("pre_rst_pw", password, sbq[0].pw);
            out_ready = 1'b0;
            rst_n = 1'b0;
            #1;
            chk_zero("async_rst");
            sbq.delete();
            @(negedge clk); #1;
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            chk_zero("post_rst");
            fin = 1;
         end else if (stop_at >= 0 && acc_cnt == stop_at) begin
            chk("stop_pw", password, sbq[0].pw);
            out_ready = 1'b0;
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            chk("stop_valid", out_valid, 0);
            chk("stop_busy", busy, 0);
            repeat (2) @(posedge clk);
            #1;
            chk("stop_cnt", cand_count, stop_at);
            chk("stop_no_done", done_cnt - d0, 0);
            sbq.delete();
            fin = 1;
         end else if (hold_at >= 0 && acc_cnt == hold_at) begin
            out_ready = 1'b0;
            repeat (5) begin
               @(posedge clk); #1;
               chk("bp_pw", password, sbq[0].pw);
               chk("bp_cnt", cand_count, hold_at);
            end
            out_ready = 1'b1;
            hold_at = -1;
            @(posedge clk); #1;
         end else begin
            out_ready  = ($urandom_range(99) < rdy_pct);
            start      = ($urandom_range(15) == 0);
            start_char = 8'($urandom);
            stride     = 3'($urandom);
            len_limit  = LEN_W'($urandom);
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != d0) begin
               fin = 1;
               chk("end_cnt", cand_count, exp_total);
               chk("end_pw", password, exp_last.pw);
               chk("end_len", word_len, exp_last.wl);
               chk("end_valid", out_valid, 0);
               chk("end_busy", busy, 0);
               chk("end_done_once", done_cnt - d0, 1);
            end
         end
         cyc++;
         if (!fin && cyc > 40000) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got %0d accepted expected %0d",
                     acc_cnt, exp_total);
            sbq.delete();
            fin = 1;
         end
      end
      out_ready = 1'b0;
      stop = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      #12;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("idle");

      run(8'h61, 3'd1, 5'd2, 100, -1, -1, -1);
      run(8'h61, 3'd1, 5'd2, 100, -1, 2, -1);
      run(8'h62, 3'd3, 5'd2, 70, -1, -1, -1);
      run(8'h41, 3'd0, 5'd1, 100, -1, -1, -1);
      run(8'h61, 3'd1, 5'd2, 100, 12, -1, -1);
      run(8'h61, 3'd1, 5'd0, 60, -1, -1, -1);
      run(8'h61, 3'd1, 5'd3, 100, -1, -1, 42);

      @(posedge clk); #1;
      start = 1'b1;
      stop  = 1'b1;
      start_char = 8'h61;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      chk("start_stop_busy", busy, 0);
      chk("start_stop_valid", out_valid, 0);

      for (int r = 0; r < 6; r++) begin
         run(8'($urandom_range('h80, 'h58)), 3'($urandom),
             5'($urandom_range(2, 0)), $urandom_range(100, 30),
             -1, -1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
